rgb_pwm_ctrl: RTL and testbench
===============================

RGB_PWM_CTRL -- requirements
Module: rgb_pwm_ctrl

Interface
- REQ-001 Parameter NCH, default 3: number of PWM channels; legal range 1..8.
- REQ-002 Parameter PWM_W, default 8: duty and counter width in bits; legal range 4..12.
- REQ-003 Parameter PRE_DIV, default 188: clk cycles per PWM counter step; minimum 1.
- REQ-004 Parameter BLINK_PER, default 250: PWM periods per blink half-phase; minimum 1.
- REQ-005 Parameter FADE_PER, default 2: PWM periods per breathe level step; minimum 1.
- REQ-006 Ports:
  - clk  in  1: system clock.
  - rst  in  1: synchronous, active-high reset.
  - wr_en  in  1: register write strobe.
  - wr_ch  in  3: target channel; values >= NCH are ignored.
  - wr_sel  in  1: 0 = duty register, 1 = mode register.
  - wr_data  in  PWM_W: write data; the mode write uses wr_data[1:0].
  - pwm  out  NCH: per-channel PWM, registered, active-high.
  - period_start  out  1: one-cycle pulse at each PWM period start.
- REQ-007 One clock domain (clk); reset is synchronous and active-high (rst); no other clocks or resets.

Function
- REQ-008 Prescaler:
  - counts 0..PRE_DIV-1 and wraps to 0;
  - step = prescaler at PRE_DIV-1; with PRE_DIV=1, step is asserted every cycle.
- REQ-009 PWM counter: PWM_W bits; increments on step; wraps from 2^PWM_W-1 to 0.
- REQ-010 Period start:
  - occurs on the step at which the PWM counter wraps to 0;
  - period_start is registered and is high the cycle after that step.
- REQ-011 Shadow registers:
  - wr_en loads the per-channel duty or mode shadow register on the same clk edge;
  - writes with wr_ch >= NCH change nothing.
- REQ-012 Active registers:
  - per channel, active duty and mode load from the shadow registers at each period start;
  - a write coinciding with the period-start edge is loaded at the following period start.
- REQ-013 Modes:
  - 0 OFF: level = 0.
  - 1 STATIC: level = duty.
  - 2 BLINK: level = duty in the on phase, 0 in the off phase.
  - 3 BREATHE: level is a triangle ramp bounded by 0 and duty.
- REQ-014 BLINK:
  - phase toggles after every BLINK_PER period starts;
  - the phase begins as on when the mode is entered.
- REQ-015 BREATHE:
  - state UP or DOWN, plus a ramp level and a FADE_PER period counter;
  - every FADE_PER period starts, UP increments the level and DOWN decrements it;
  - UP -> DOWN when the level equals duty; DOWN -> UP when the level equals 0.
- REQ-016 BREATHE with duty 0: level holds 0 and the state stays UP.
- REQ-017 BREATHE with duty lowered below the current ramp level: at the loading period start, level clamps to duty and the state becomes DOWN.
- REQ-018 Mode change: when the active mode changes, that channel's ramp level is set to 0, the state to UP, and the blink phase to on, in the same edge.
- REQ-019 Compare:
  - pwm[c] next = (counter < level[c]);
  - level 0 gives a constant low output;
  - level 2^PWM_W-1 gives a constant high output (full-on special case, no single-step low).
- REQ-020 Latency:
  - a write at cycle t affects pwm starting the cycle after the first period start strictly after t;
  - the compare-to-pwm latency is 1 cycle.
- REQ-021 Channels are fully independent; a write to one channel never disturbs another channel's phase or ramp.
- REQ-022 All arithmetic is unsigned; the ramp never exceeds duty and never underflows below 0.

Reset
- REQ-023 While rst is high at a clk edge, every register is cleared to 0: prescaler, counter, all shadow and active registers, ramp levels, blink counters, and fade counters.
- REQ-024 Reset state values: mode = OFF, state = UP, blink phase = on, pwm = 0, period_start = 0.
- REQ-025 Reset mid-period: pwm is 0 the cycle after the rst edge; counting restarts from 0 the cycle after rst falls.
- REQ-026 wr_en is ignored while rst is high.

Verification (bench parameters: NCH=3, PWM_W=4, PRE_DIV=2, BLINK_PER=2, FADE_PER=1)
- REQ-027 Write ch0 duty=4, mode=1 -> from the second period start onward, pwm[0] is high 8 of every 32 cycles, and pwm[1] and pwm[2] stay 0.
- REQ-028 Duty=15 in STATIC -> pwm constant 1; duty=0 -> pwm constant 0; period_start pulses every 32 cycles.
- REQ-029 ch1 duty=3, mode=3 -> level sequence per period is 0,1,2,3,2,1,0,1,...; lowering duty to 1 at level 3 gives 1,0,1,0.
- REQ-030 ch2 duty=8, mode=2 -> level 8 for 2 periods, then 0 for 2 periods, repeating; switching to mode 1 restores level 8 at the next period start.
- REQ-031 Write coinciding with the period-start edge -> the old value holds for that period and the new value applies at the next period; a write with wr_ch=5 changes no output.
- REQ-032 Assert rst for 1 cycle mid-period with all channels active -> all pwm=0 the next cycle, all modes OFF, and the first period_start occurs 32 cycles after rst falls.

Source files
------------

// File: rtl/rgb_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// rgb_pwm_ctrl
//
// Multi-channel PWM LED controller. A shared prescaler and PWM counter define
// the PWM period. Each channel has shadow duty/mode registers written from the
// host side and active copies that reload only at the start of a PWM period,
// so a duty or mode change never produces a glitched period.
//
// Per-channel modes (wr_data[1:0] on a mode write):
//   0 OFF      level = 0
//   1 STATIC   level = duty
//   2 BLINK    level alternates duty / 0 every BLINK_PER periods (starts on)
//   3 BREATHE  level ramps 0 -> duty -> 0 one step every FADE_PER periods
//
// Ports
//   clk           system clock
//   rst           synchronous active-high reset
//   wr_en         register write strobe
//   wr_ch         target channel (writes to channels >= NCH are dropped)
//   wr_sel        0 = duty register, 1 = mode register
//   wr_data       write data (mode uses bits [1:0])
//   pwm           registered per-channel PWM outputs, active-high
//   period_start  one-cycle pulse on the first cycle of every PWM period
//
// Write handshake: a write is a single-cycle strobe with no back-pressure;
// wr_en high at a rising clk edge (with rst low) commits wr_data to the
// addressed shadow register at that edge.
// -----------------------------------------------------------------------------
module rgb_pwm_ctrl #(
   parameter int NCH       = 3,
   parameter int PWM_W     = 8,
   parameter int PRE_DIV   = 188,
   parameter int BLINK_PER = 250,
   parameter int FADE_PER  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_en,
   input  logic [2:0]       wr_ch,
   input  logic             wr_sel,
   input  logic [PWM_W-1:0] wr_data,
   output logic [NCH-1:0]   pwm,
   output logic             period_start
);

   localparam int PRE_W = (PRE_DIV   > 1) ? $clog2(PRE_DIV)   : 1;
   localparam int BL_W  = (BLINK_PER > 1) ? $clog2(BLINK_PER) : 1;
   localparam int FD_W  = (FADE_PER  > 1) ? $clog2(FADE_PER)  : 1;

   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);
   localparam logic [BL_W-1:0]  BL_LAST  = BL_W'(BLINK_PER - 1);
   localparam logic [FD_W-1:0]  FD_LAST  = FD_W'(FADE_PER - 1);
   localparam logic [PWM_W-1:0] CNT_MAX  = '1;
   localparam logic [PWM_W-1:0] ONE_W    = PWM_W'(1);

   typedef enum logic [1:0] {
      MODE_OFF     = 2'd0,
      MODE_STATIC  = 2'd1,
      MODE_BLINK   = 2'd2,
      MODE_BREATHE = 2'd3
   } mode_e;

   // Breathe ramp direction; UP encodes as 0 so reset leaves it UP.
   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   // ---------------------------------------------------------------------------
   // Shared timebase
   // ---------------------------------------------------------------------------
   logic [PRE_W-1:0] pre_q, pre_d;
   logic [PWM_W-1:0] cnt_q, cnt_d;
   logic             period_start_q;
   logic             step;
   logic             ps_evt;   // the edge at which the counter wraps to 0

   // ---------------------------------------------------------------------------
   // Per-channel registers
   // ---------------------------------------------------------------------------
   logic [PWM_W-1:0] sh_duty_q   [NCH];
   logic [PWM_W-1:0] sh_duty_d   [NCH];
   mode_e            sh_mode_q   [NCH];
   mode_e            sh_mode_d   [NCH];
   logic [PWM_W-1:0] act_duty_q  [NCH];
   logic [PWM_W-1:0] act_duty_d  [NCH];
   mode_e            act_mode_q  [NCH];
   mode_e            act_mode_d  [NCH];
   logic [PWM_W-1:0] ramp_q      [NCH];
   logic [PWM_W-1:0] ramp_d      [NCH];
   dir_e             dir_q       [NCH];
   dir_e             dir_d       [NCH];
   logic [BL_W-1:0]  blink_cnt_q [NCH];
   logic [BL_W-1:0]  blink_cnt_d [NCH];
   logic [FD_W-1:0]  fade_cnt_q  [NCH];
   logic [FD_W-1:0]  fade_cnt_d  [NCH];
   logic [NCH-1:0]   blink_off_q, blink_off_d;   // 0 = on phase
   logic [PWM_W-1:0] lvl         [NCH];
   logic [NCH-1:0]   pwm_q, pwm_d;
   logic             wr_hit;

   // ---------------------------------------------------------------------------
   // Timebase next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      step   = (pre_q == PRE_LAST);
      pre_d  = step ? '0 : pre_q + PRE_W'(1);
      cnt_d  = step ? cnt_q + ONE_W : cnt_q;
      ps_evt = step && (cnt_q == CNT_MAX);
      wr_hit = wr_en && ({1'b0, wr_ch} < 4'(NCH));
   end

   // ---------------------------------------------------------------------------
   // Channel next-state: shadow writes, period-start reload, blink and breathe
   // ---------------------------------------------------------------------------
   always_comb begin
      blink_off_d = blink_off_q;
      for (int c = 0; c < NCH; c++) begin
         sh_duty_d[c]   = sh_duty_q[c];
         sh_mode_d[c]   = sh_mode_q[c];
         act_duty_d[c]  = act_duty_q[c];
         act_mode_d[c]  = act_mode_q[c];
         ramp_d[c]      = ramp_q[c];
         dir_d[c]       = dir_q[c];
         blink_cnt_d[c] = blink_cnt_q[c];
         fade_cnt_d[c]  = fade_cnt_q[c];

         // The shadow updates on the write edge; a write landing on the
         // period-start edge is therefore seen by the reload one period later,
         // because the reload below samples the pre-edge shadow value.
         if (wr_hit && (wr_ch == 3'(c))) begin
            if (wr_sel) sh_mode_d[c] = mode_e'(wr_data[1:0]);
            else        sh_duty_d[c] = wr_data;
         end

         if (ps_evt) begin
            act_duty_d[c] = sh_duty_q[c];
            act_mode_d[c] = sh_mode_q[c];

            if (sh_mode_q[c] != act_mode_q[c]) begin
               // Entering a new mode always starts from a clean animation.
               ramp_d[c]      = '0;
               dir_d[c]       = DIR_UP;
               blink_off_d[c] = 1'b0;
               blink_cnt_d[c] = '0;
               fade_cnt_d[c]  = '0;
            end else begin
               case (act_mode_q[c])
                  MODE_BLINK: begin
                     if (blink_cnt_q[c] == BL_LAST) begin
                        blink_cnt_d[c] = '0;
                        blink_off_d[c] = ~blink_off_q[c];
                     end else begin
                        blink_cnt_d[c] = blink_cnt_q[c] + BL_W'(1);
                     end
                  end
                  MODE_BREATHE: begin
                     if (fade_cnt_q[c] == FD_LAST) fade_cnt_d[c] = '0;
                     else                          fade_cnt_d[c] = fade_cnt_q[c] + FD_W'(1);

                     if (sh_duty_q[c] == '0) begin
                        ramp_d[c] = '0;
                        dir_d[c]  = DIR_UP;
                     end else if (ramp_q[c] > sh_duty_q[c]) begin
                        // Duty was lowered under the ramp: clamp and head down.
                        ramp_d[c] = sh_duty_q[c];
                        dir_d[c]  = DIR_DOWN;
                     end else if (fade_cnt_q[c] == FD_LAST) begin
                        // Move up while below the top (or when sitting at 0),
                        // otherwise down. Direction flips on reaching a bound.
                        if ((dir_q[c] == DIR_UP && ramp_q[c] < sh_duty_q[c]) ||
                            (ramp_q[c] == '0)) begin
                           ramp_d[c] = ramp_q[c] + ONE_W;
                           dir_d[c]  = ((ramp_q[c] + ONE_W) == sh_duty_q[c]) ? DIR_DOWN : DIR_UP;
                        end else begin
                           ramp_d[c] = ramp_q[c] - ONE_W;
                           dir_d[c]  = ((ramp_q[c] - ONE_W) == '0) ? DIR_UP : DIR_DOWN;
                        end
                     end
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Level selection and compare
   // ---------------------------------------------------------------------------
   always_comb begin
      pwm_d = '0;
      for (int c = 0; c < NCH; c++) begin
         lvl[c] = '0;
         case (act_mode_q[c])
            MODE_STATIC:  lvl[c] = act_duty_q[c];
            MODE_BLINK:   lvl[c] = blink_off_q[c] ? '0 : act_duty_q[c];
            MODE_BREATHE: lvl[c] = ramp_q[c];
            default:      lvl[c] = '0;
         endcase
         // The counter never exceeds CNT_MAX, so the top level is forced
         // fully on instead of leaving one low step per period.
         pwm_d[c] = (lvl[c] == CNT_MAX) || (cnt_q < lvl[c]);
      end
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q          <= '0;
         cnt_q          <= '0;
         period_start_q <= 1'b0;
         pwm_q          <= '0;
         blink_off_q    <= '0;
         for (int c = 0; c < NCH; c++) begin
            sh_duty_q[c]   <= '0;
            sh_mode_q[c]   <= MODE_OFF;
            act_duty_q[c]  <= '0;
            act_mode_q[c]  <= MODE_OFF;
            ramp_q[c]      <= '0;
            dir_q[c]       <= DIR_UP;
            blink_cnt_q[c] <= '0;
            fade_cnt_q[c]  <= '0;
         end
      end else begin
         pre_q          <= pre_d;
         cnt_q          <= cnt_d;
         period_start_q <= ps_evt;
         pwm_q          <= pwm_d;
         blink_off_q    <= blink_off_d;
         for (int c = 0; c < NCH; c++) begin
            sh_duty_q[c]   <= sh_duty_d[c];
            sh_mode_q[c]   <= sh_mode_d[c];
            act_duty_q[c]  <= act_duty_d[c];
            act_mode_q[c]  <= act_mode_d[c];
            ramp_q[c]      <= ramp_d[c];
            dir_q[c]       <= dir_d[c];
            blink_cnt_q[c] <= blink_cnt_d[c];
            fade_cnt_q[c]  <= fade_cnt_d[c];
         end
      end
   end

   assign pwm          = pwm_q;
   assign period_start = period_start_q;

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rgb_pwm_ctrl
//
// Bench for rgb_pwm_ctrl with NCH=3, PWM_W=4, PRE_DIV=2, BLINK_PER=2,
// FADE_PER=1 (one PWM period = 32 clk cycles). Each table row describes one
// PWM period: the writes issued during it and the level every channel must
// show in it. The expected 32-cycle waveform of pwm[2:0] and period_start is
// built from those levels and queued, then compared against the captured
// waveform when the period ends.
// -----------------------------------------------------------------------------
module tb_rgb_pwm_ctrl;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [2:0] wr_ch;
  logic       wr_sel;
  logic [3:0] wr_data;
  logic [2:0] pwm;
  logic       period_start;

  int n_cmp;
  int n_err;

  logic [127:0] exp_q[$];

  typedef struct {
    bit         en;
    logic [2:0] ch;
    logic       sel;
    logic [3:0] data;
    bit         late;   // issue on the period-start edge instead of early
  } wr_t;

  typedef struct {
    wr_t w0;
    wr_t w1;
    int  lv0;
    int  lv1;
    int  lv2;
  } vec_t;

  localparam int NROWS = 23;
  vec_t tbl[NROWS];

  rgb_pwm_ctrl #(
    .NCH(3), .PWM_W(4), .PRE_DIV(2), .BLINK_PER(2), .FADE_PER(1)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
    .wr_data(wr_data), .pwm(pwm), .period_start(period_start)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Helpers
  // ---------------------------------------------------------------------------
  function automatic wr_t mkw(input int ch, input int sel, input int data, input bit late);
    wr_t w;
    w.en = 1'b1; w.ch = 3'(ch); w.sel = sel[0]; w.data = 4'(data); w.late = late;
    return w;
  endfunction

  function automatic wr_t now();
    wr_t w;
    w.en = 1'b0; w.ch = '0; w.sel = 1'b0; w.data = '0; w.late = 1'b0;
    return w;
  endfunction

  function automatic vec_t mkv(input wr_t a, input wr_t b, input int l0, input int l1, input int l2);
    vec_t v;
    v.w0 = a; v.w1 = b; v.lv0 = l0; v.lv1 = l1; v.lv2 = l2;
    return v;
  endfunction

  // Waveform of one period sampled on cycles P+1..P+32 after a period_start
  // cycle P: counter value is j/2 on sample j, and period_start recurs on the
  // last sample.
  function automatic logic [127:0] build(input int l0, input int l1, input int l2);
    logic [127:0] e;
    int lv[3];
    lv[0] = l0; lv[1] = l1; lv[2] = l2;
    e = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int j = 0; j < 32; j++)
        e[ch*32 + j] = ((j / 2) < lv[ch]) || (lv[ch] == 15);
    e[127] = 1'b1;
    return e;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_wr(input wr_t w);
    wr_en   = 1'b1;
    wr_ch   = w.ch;
    wr_sel  = w.sel;
    wr_data = w.data;
  endtask

  // Called on the negedge of a period_start cycle; ends on the negedge of the
  // next one.
  task automatic run_period(input string name, input vec_t v);
    logic [127:0] got;
    exp_q.push_back(build(v.lv0, v.lv1, v.lv2));
    got = '0;
    for (int j = 0; j < 32; j++) begin
      @(negedge clk);
      got[j]      = pwm[0];
      got[32 + j] = pwm[1];
      got[64 + j] = pwm[2];
      got[96 + j] = period_start;
      wr_en = 1'b0;
      if (v.w0.en && ((!v.w0.late && j == 0) || (v.w0.late && j == 30))) drive_wr(v.w0);
      if (v.w1.en && ((!v.w1.late && j == 1) || (v.w1.late && j == 30))) drive_wr(v.w1);
    end
    wr_en = 1'b0;
    check(name, got, exp_q.pop_front());
  endtask

  // Counts negedges from now until period_start is seen (bounded).
  task automatic wait_ps(output int n, output logic any_pwm);
    n = 0;
    any_pwm = 1'b0;
    do begin
      @(negedge clk);
      n++;
      any_pwm = any_pwm | (|pwm);
    end while (!period_start && n < 100);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus and checking
  // ---------------------------------------------------------------------------
  initial begin
    int   n;
    logic any_pwm;

    n_cmp = 0; n_err = 0;
    rst = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_sel = 1'b0; wr_data = '0;

    tbl[0]  = mkv(mkw(0,0,4,0),  mkw(0,1,1,0), 0, 0, 0);
    tbl[1]  = mkv(mkw(1,0,3,0),  mkw(1,1,3,0), 4, 0, 0);
    tbl[2]  = mkv(mkw(2,0,8,0),  mkw(2,1,2,0), 4, 0, 0);
    tbl[3]  = mkv(mkw(5,0,15,0), mkw(5,1,3,0), 4, 1, 8);
    tbl[4]  = mkv(now(), now(), 4, 2, 8);
    tbl[5]  = mkv(now(), now(), 4, 3, 0);
    tbl[6]  = mkv(now(), now(), 4, 2, 0);
    tbl[7]  = mkv(now(), now(), 4, 1, 8);
    tbl[8]  = mkv(now(), now(), 4, 0, 8);
    tbl[9]  = mkv(now(), now(), 4, 1, 0);
    tbl[10] = mkv(now(), now(), 4, 2, 0);
    tbl[11] = mkv(mkw(1,0,1,0),  now(), 4, 3, 8);
    tbl[12] = mkv(mkw(2,1,1,0),  now(), 4, 1, 8);
    tbl[13] = mkv(mkw(0,0,15,0), now(), 4, 0, 8);
    tbl[14] = mkv(mkw(0,0,0,0),  now(), 15, 1, 8);
    tbl[15] = mkv(mkw(2,0,5,1),  now(), 0, 0, 8);
    tbl[16] = mkv(now(), now(), 0, 1, 8);
    tbl[17] = mkv(mkw(1,0,0,0),  now(), 0, 0, 5);
    tbl[18] = mkv(now(), now(), 0, 0, 5);
    tbl[19] = mkv(mkw(1,0,2,0),  now(), 0, 0, 5);
    tbl[20] = mkv(mkw(0,0,9,0),  now(), 0, 1, 5);
    tbl[21] = mkv(now(), now(), 9, 2, 5);
    tbl[22] = mkv(now(), now(), 9, 1, 5);

    // Reset with writes attempted while rst is high (must be dropped).
    repeat (2) @(negedge clk);
    check("reset_pwm", 128'(pwm), 128'(0));
    check("reset_ps", 128'(period_start), 128'(0));
    drive_wr(mkw(0,0,15,0));
    @(negedge clk);
    drive_wr(mkw(0,1,1,0));
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0;

    wait_ps(n, any_pwm);
    check("first_ps_delay", 128'(n), 128'(32));
    check("first_period_pwm", 128'(any_pwm), 128'(0));

    for (int i = 0; i < NROWS; i++)
      run_period($sformatf("row%0d", i), tbl[i]);

    // Mid-period reset with channels active.
    repeat (9) @(negedge clk);
    check("pre_reset_pwm", 128'(pwm), 128'(3'b101));
    rst = 1'b1;
    @(negedge clk);
    check("post_reset_pwm", 128'(pwm), 128'(0));
    check("post_reset_ps", 128'(period_start), 128'(0));
    rst = 1'b0;
    wait_ps(n, any_pwm);
    check("reset_ps_delay", 128'(n), 128'(32));
    check("reset_period_pwm", 128'(any_pwm), 128'(0));
    run_period("after_reset_off", mkv(now(), now(), 0, 0, 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
